i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (responder) with an internal byte-wide register file. It is the bus-side counterpart to the open-drain pin model and to the I2C master used in the verilog-i2c bench. The block samples SCL/SDA, decodes START/STOP, answers its 7-bit address, and supports pointer-addressed writes plus sequential reads. Every accepted write byte is also reported on a one-cycle strobe port.

## Interface
- ADDR, 7'h50, 7-bit target address
- DEPTH, 16, register file depth in bytes; power of two, 2..256
- FILTER, 3, consecutive identical samples needed before a filtered line changes (glitch rejection)

- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- scl_i  input  1  SCL as seen on the bus
- sda_i  input  1  SDA as seen on the bus
- sda_o  output  1  SDA drive value; constant 0 (open drain)
- sda_t  output  1  SDA tristate control; 1 = release (Z), 0 = drive sda_o
- busy  output  1  high from START through STOP
- wr_valid  output  1  one-cycle strobe per written data byte
- wr_addr  output  $clog2(DEPTH)  register index of the write
- wr_data  output  8  written byte

## Operation
- **Input conditioning.** Each input passes through a 2-flop synchronizer, then a filter. The filtered level changes only after FILTER equal consecutive samples. The filter also generates rise and fall pulses.
- **Bus conditions.**
  - START (including repeated START): filtered SDA falls while SCL is high.
  - STOP: filtered SDA rises while SCL is high.
- **Bit timing.** Bits are sampled on the SCL rising pulse. The SDA drive state changes only on the SCL falling pulse.
- **States.**
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits, MSB first. At the 8th SCL fall: if bits[7:1] == ADDR, go to ADDR_ACK; otherwise go to IGNORE.
  - ADDR_ACK: drive SDA low for one SCL period. Next state is PTR if R/W = 0, RDATA if R/W = 1.
  - PTR → PTR_ACK: load ptr with byte[$clog2(DEPTH)-1:0]; upper bits are ignored. Then go to WDATA.
  - WDATA → WDATA_ACK: write the byte to reg[ptr], pulse wr_valid, increment ptr. Then go to WDATA.
  - RDATA: at each SCL fall, sda_t = reg[ptr] bit (MSB first; 1 = release). After the 8th bit, release SDA, increment ptr, and go to RACK.
  - RACK: sample the master's bit. 0 (ACK) → RDATA. 1 (NACK) → IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **Global transitions.** START in any state → ADDR. STOP in any state → IDLE.
- **Pointer behaviour.**
  - ptr wraps modulo DEPTH.
  - ptr persists across transactions, so a repeated START followed by a read continues from the written pointer.
- **Aborts.** START or STOP before a byte's 8th bit aborts that byte: no write, no wr_valid, no ptr change.

## Timing
- Reset values:
  - sda_t = 1, sda_o = 0, busy = 0
  - wr_valid = 0, wr_addr = 0, wr_data = 0
  - ptr = 0, all registers = 0
  - state = IDLE
- Input latency: 2 (synchronizer) + FILTER clk cycles from a pin change to the filtered edge pulse.
- The reg write, wr_valid, wr_addr and wr_data update on the clk cycle after the 8th-bit rising pulse.
- sda_t changes on the clk cycle after the filtered SCL falling pulse.
- ACK is held low from the 8th SCL fall to the 9th SCL fall.
- busy rises one cycle after the START pulse and falls one cycle after the STOP pulse.
- rst asserted mid-transfer: sda_t = 1 on the next clk edge and the state returns to IDLE.
- No clock stretching; SCL is never driven.

## Structure
- Package i2c_target_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE)
  - constants I2C_ACK = 0, I2C_NACK = 1, I2C_RW_WRITE = 0
- Sub-module i2c_in_filter: synchronizer + FILTER-deep glitch filter + rise/fall pulses. It is instantiated once for SCL and once for SDA.
- The top level holds the FSM, bit counter (0..8), shift register, ptr, and register array.

## Test plan
All scenarios use ADDR = 0x50, DEPTH = 16, FILTER = 3, and the bench drives the bus through the pin model.
1. START, 0xA0, 0x03, 0x5A, 0xC3, STOP → sda_t = 0 on all four 9th clocks; wr_valid pulses with (3, 0x5A) then (4, 0xC3); busy low after STOP.
2. START, 0xA0, 0x03, repeated START, 0xA1; master reads with ACK then NACK, then STOP → bytes read are 0x5A then 0xC3; after the NACK, SDA stays released.
3. START, 0xA2, 0x00, STOP (wrong address) → sda_t = 1 throughout; no wr_valid; registers unchanged.
4. Pointer 0x0F, writes 0x11 and 0x22 → wr_addr = 15 then 0; a read from pointer 0x0F returns 0x11 then 0x22.
5. STOP after 4 data bits of 0xFF → no wr_valid, ptr unchanged, state IDLE. A 2-cycle low glitch on SCL during a byte shifts no bit.
6. rst pulsed while the target is driving a 0 data bit → sda_t = 1 on the next cycle; all outputs at reset values; the next valid transaction completes normally.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared state encoding and bus-level constants for the I2C register target.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_in_filter.sv
// Pin conditioner: 2-flop synchronizer plus FILTER-sample glitch filter with edge pulses.
// Latency 2 + FILTER cycles from pin change to level/pulse; no backpressure.
module i2c_in_filter #(
    parameter int FILTER = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER + 1);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          r_rise;
    logic          r_fall;

    // Bus idles high, so everything resets to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_cnt  <= '0;
            r_lvl  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_s2 != r_lvl) begin
                if (r_cnt == CW'(FILTER - 1)) begin
                    r_lvl  <= r_s2;
                    r_rise <= r_s2;
                    r_fall <= ~r_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register file: pointer-addressed writes, sequential reads.
// SDA reacts one cycle after a filtered SCL fall; no clock stretching.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR   = 7'h50,
    parameter int         DEPTH  = 16,
    parameter int         FILTER = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_o,
    output logic                     sda_t,
    output logic                     busy,
    output logic                     wr_valid,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data
);

    localparam int PW = $clog2(DEPTH);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    i2c_in_filter #(.FILTER(FILTER)) u_scl_filt (
        .clk(clk), .rst(rst), .i_pin(scl_i),
        .o_lvl(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_in_filter #(.FILTER(FILTER)) u_sda_filt (
        .clk(clk), .rst(rst), .i_pin(sda_i),
        .o_lvl(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    state_t        r_state;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_rw;
    logic [PW-1:0] r_ptr;
    logic [7:0]    r_regs [DEPTH];
    logic          r_sda_t;
    logic          r_busy;
    logic          r_wr_valid;
    logic [PW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;

    logic          w_start;
    logic          w_stop;
    logic [7:0]    w_byte;
    logic          w_last_rise;
    logic [7:0]    w_rd_byte;
    logic [2:0]    w_bit_idx;

    assign w_start     = w_sda_fall & w_scl_lvl;
    assign w_stop      = w_sda_rise & w_scl_lvl;
    assign w_byte      = {r_shift[6:0], w_sda_lvl};
    assign w_last_rise = w_scl_rise && (r_bitcnt == 4'd7);
    assign w_rd_byte   = r_regs[r_ptr];
    assign w_bit_idx   = 3'(4'd7 - r_bitcnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 4'd0;
            r_shift    <= 8'd0;
            r_rw       <= 1'b0;
            r_ptr      <= '0;
            r_sda_t    <= 1'b1;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'd0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_start) begin
                r_state  <= ST_ADDR;
                r_bitcnt <= 4'd0;
                r_sda_t  <= 1'b1;
                r_busy   <= 1'b1;
            end else if (w_stop) begin
                r_state <= ST_IDLE;
                r_sda_t <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                // Data bytes commit on the 8th rise so a later START/STOP cannot undo them.
                if (w_scl_rise) begin
                    r_shift <= w_byte;
                    if (r_bitcnt != 4'd8) r_bitcnt <= r_bitcnt + 4'd1;
                    if (w_last_rise && r_state == ST_PTR) r_ptr <= w_byte[PW-1:0];
                    if (w_last_rise && r_state == ST_WDATA) begin
                        r_regs[r_ptr] <= w_byte;
                        r_wr_valid    <= 1'b1;
                        r_wr_addr     <= r_ptr;
                        r_wr_data     <= w_byte;
                        r_ptr         <= r_ptr + PW'(1);
                    end
                end
                if (w_scl_fall) begin
                    case (r_state)
                        ST_ADDR: if (r_bitcnt == 4'd8) begin
                            r_rw     <= r_shift[0];
                            r_bitcnt <= 4'd0;
                            if (r_shift[7:1] == ADDR) begin
                                r_state <= ST_ADDR_ACK;
                                r_sda_t <= I2C_ACK;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                        ST_ADDR_ACK: begin
                            r_bitcnt <= 4'd0;
                            if (r_rw == I2C_RW_WRITE) begin
                                r_state <= ST_PTR;
                                r_sda_t <= 1'b1;
                            end else begin
                                r_state <= ST_RDATA;
                                r_sda_t <= w_rd_byte[7];
                            end
                        end
                        ST_PTR, ST_WDATA: if (r_bitcnt == 4'd8) begin
                            r_state  <= (r_state == ST_PTR) ? ST_PTR_ACK : ST_WDATA_ACK;
                            r_sda_t  <= I2C_ACK;
                            r_bitcnt <= 4'd0;
                        end
                        ST_PTR_ACK, ST_WDATA_ACK: begin
                            r_state  <= ST_WDATA;
                            r_sda_t  <= 1'b1;
                            r_bitcnt <= 4'd0;
                        end
                        ST_RDATA: begin
                            if (r_bitcnt == 4'd8) begin
                                r_state  <= ST_RACK;
                                r_sda_t  <= 1'b1;
                                r_ptr    <= r_ptr + PW'(1);
                                r_bitcnt <= 4'd0;
                            end else begin
                                r_sda_t <= w_rd_byte[w_bit_idx];
                            end
                        end
                        ST_RACK: begin
                            r_bitcnt <= 4'd0;
                            if (r_shift[0] == I2C_NACK) begin
                                r_state <= ST_IGNORE;
                                r_sda_t <= 1'b1;
                            end else begin
                                r_state <= ST_RDATA;
                                r_sda_t <= w_rd_byte[7];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign sda_o    = 1'b0;
    assign sda_t    = r_sda_t;
    assign busy     = r_busy;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: open-drain bus model, bit-banged master, byte-level reference model.
module tb_i2c_target_regs;

    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_o, sda_t, busy, wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    assign sda_bus = m_sda & (sda_t | sda_o);

    i2c_target_regs #(.ADDR(7'h50), .DEPTH(16), .FILTER(3)) dut (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_t(sda_t), .busy(busy),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mem [16];
    logic [3:0]  mptr;
    logic [11:0] exp_wr[$];
    logic [11:0] got_wr[$];
    int          got_rd = 0;
    logic [7:0]  txd[$];
    int          release_viol = 0;
    logic        watch_release = 1'b0;

    always @(negedge clk) begin
        if (wr_valid) got_wr.push_back({wr_addr, wr_data});
        if (watch_release && !sda_t) release_viol++;
    end

    task automatic wq(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic glitch, output logic bus_v, output logic t_v);
        wq(1); m_sda = b; wq(1); m_scl = 1'b1;
        if (glitch) begin
            repeat (6) @(negedge clk); m_scl = 1'b0;
            repeat (2) @(negedge clk); m_scl = 1'b1;
        end
        wq(1); bus_v = sda_bus; t_v = sda_t;
        wq(1); m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack_t);
        logic bv, tv;
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit, bv, tv);
        send_bit(1'b1, 1'b0, bv, ack_t);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic bv, tv;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, bv, tv);
            d[i] = bv;
        end
        send_bit(ack, 1'b0, bv, tv);
    endtask

    task automatic bus_start();
        if (!m_scl) begin
            wq(1); m_sda = 1'b1; wq(1); m_scl = 1'b1; wq(1);
        end
        m_sda = 1'b0; wq(1); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wq(1); m_sda = 1'b0; wq(1); m_scl = 1'b1; wq(1); m_sda = 1'b1; wq(2);
    endtask

    // Addressed write of pointer p followed by the bytes in txd.
    task automatic tx_write(input logic [6:0] a, input logic [7:0] p, input int gbit);
        logic        ack, hit;
        int          base;
        logic [11:0] e;
        hit  = (a == 7'h50);
        base = release_viol;
        watch_release = ~hit;
        bus_start();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b want 1", busy); end
        send_byte({a, 1'b0}, -1, ack);
        n_vec++;
        if (ack !== ~hit) begin n_err++; $display("FAIL addr_ack a=%h: got %b want %b", a, ack, ~hit); end
        send_byte(p, -1, ack);
        n_vec++;
        if (ack !== ~hit) begin n_err++; $display("FAIL ptr_ack: got %b want %b", ack, ~hit); end
        if (hit) mptr = p[3:0];
        foreach (txd[i]) begin
            send_byte(txd[i], (i == 0) ? gbit : -1, ack);
            n_vec++;
            if (ack !== ~hit) begin n_err++; $display("FAIL data_ack %0d: got %b want %b", i, ack, ~hit); end
            if (hit) begin
                exp_wr.push_back({mptr, txd[i]});
                mem[mptr] = txd[i];
                mptr++;
            end
        end
        bus_stop();
        watch_release = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_stop: got %b want 0", busy); end
        if (!hit) begin
            n_vec++;
            if (release_viol != base) begin
                n_err++; $display("FAIL released_wrong_addr: got %0d driven cycles want 0", release_viol - base);
            end
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            n_vec++;
            if (got_rd >= got_wr.size()) begin
                n_err++; $display("FAIL wr_event: got none want %h", e);
            end else begin
                if (got_wr[got_rd] !== e) begin
                    n_err++; $display("FAIL wr_event: got %h want %h", got_wr[got_rd], e);
                end
                got_rd++;
            end
        end
        n_vec++;
        if (got_wr.size() != got_rd) begin
            n_err++; $display("FAIL wr_extra: got %0d events want %0d", got_wr.size(), got_rd);
            got_rd = got_wr.size();
        end
    endtask

    // Sequential read of nr bytes, optionally setting the pointer via repeated START.
    task automatic tx_read(input int nr, input logic set_ptr, input logic [7:0] p);
        logic       ack;
        logic [7:0] d;
        int         base;
        bus_start();
        if (set_ptr) begin
            send_byte(8'hA0, -1, ack);
            n_vec++;
            if (ack !== 1'b0) begin n_err++; $display("FAIL rd_addr_w_ack: got %b want 0", ack); end
            send_byte(p, -1, ack);
            n_vec++;
            if (ack !== 1'b0) begin n_err++; $display("FAIL rd_ptr_ack: got %b want 0", ack); end
            mptr = p[3:0];
            bus_start();
        end
        send_byte(8'hA1, -1, ack);
        n_vec++;
        if (ack !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
        for (int i = 0; i < nr; i++) begin
            recv_byte(i == nr - 1, d);
            n_vec++;
            if (d !== mem[mptr]) begin
                n_err++; $display("FAIL read_byte ptr=%0d: got %h want %h", mptr, d, mem[mptr]);
            end
            mptr++;
        end
        base = release_viol;
        watch_release = 1'b1;
        wq(2);
        bus_stop();
        watch_release = 1'b0;
        n_vec++;
        if (release_viol != base) begin
            n_err++; $display("FAIL released_after_nack: got %0d driven cycles want 0", release_viol - base);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if ({sda_t, sda_o, busy, wr_valid} !== 4'b1000) begin
            n_err++; $display("FAIL %s ctrl: got t=%b o=%b busy=%b vld=%b want 1000", tag, sda_t, sda_o, busy, wr_valid);
        end
        n_vec++;
        if ({wr_addr, wr_data} !== 12'h000) begin
            n_err++; $display("FAIL %s wr_bus: got %h want 000", tag, {wr_addr, wr_data});
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mptr = 4'd0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_outputs("reset");
    endtask

    task automatic test_write_basic();
        txd = '{8'h5A, 8'hC3};
        tx_write(7'h50, 8'h03, -1);
    endtask

    task automatic test_repeated_read();
        tx_read(2, 1'b1, 8'h03);
    endtask

    task automatic test_wrong_addr();
        txd = '{};
        tx_write(7'h51, 8'h00, -1);
    endtask

    task automatic test_wrap();
        txd = '{8'h11, 8'h22};
        tx_write(7'h50, 8'h0F, -1);
        tx_read(2, 1'b1, 8'h0F);
    endtask

    task automatic test_abort_glitch();
        logic ack, bv, tv;
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h03, -1, ack);
        n_vec++;
        if (ack !== 1'b0) begin n_err++; $display("FAIL abort_ptr_ack: got %b want 0", ack); end
        mptr = 4'd3;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, bv, tv);
        bus_stop();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_vec++;
        if (got_wr.size() != got_rd) begin
            n_err++; $display("FAIL abort_wr: got %0d events want %0d", got_wr.size(), got_rd);
            got_rd = got_wr.size();
        end
        tx_read(2, 1'b0, 8'h00);
        txd = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        tx_write(7'h50, 8'h08, 4);
        tx_read(2, 1'b1, 8'h08);
    endtask

    task automatic test_reset_midread();
        logic ack, bv, tv;
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h03, -1, ack);
        mptr = 4'd3;
        bus_start();
        send_byte(8'hA1, -1, ack);
        wq(1); m_sda = 1'b1; wq(1); m_scl = 1'b1; wq(1);
        n_vec++;
        if (sda_t !== mem[3][7]) begin n_err++; $display("FAIL midread_drive: got %b want %b", sda_t, mem[3][7]); end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midread_reset");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mptr = 4'd0;
        wq(1);
        tx_read(1, 1'b0, 8'h00);
        txd = '{8'h3C, 8'hA5};
        tx_write(7'h50, 8'h06, -1);
        tx_read(2, 1'b1, 8'h06);
        bv = 1'b0; tv = bv;
    endtask

    task automatic test_random();
        int         kind;
        logic [6:0] a;
        for (int it = 0; it < 6; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                txd = '{};
                for (int j = 0; j < $urandom_range(1, 3); j++) txd.push_back(8'($urandom_range(0, 255)));
                tx_write(7'h50, 8'($urandom_range(0, 255)), -1);
            end else if (kind == 1) begin
                tx_read($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end else begin
                do a = 7'($urandom_range(0, 127)); while (a == 7'h50);
                txd = '{8'($urandom_range(0, 255))};
                tx_write(a, 8'($urandom_range(0, 255)), -1);
            end
        end
        tx_read(3, 1'b1, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_repeated_read();
        test_wrong_addr();
        test_wrap();
        test_abort_glitch();
        test_reset_midread();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
